// File: rtl/hopfield_weight_trainer.sv
// On-chip Hebbian trainer for an N-neuron Hopfield network. It sweeps the N*N weight
// array once per learned pattern and serves registered weights to the detector.
module hopfield_weight_trainer #(
    parameter int N        = 16,
    parameter int W_W      = 8,
    parameter int MAX_PATT = 4,
    localparam int AW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           patt_valid,
    output logic           patt_ready,
    input  logic [N-1:0]   patt_in,
    input  logic           clear,
    output logic           busy,
    output logic [7:0]     patt_count,
    input  logic           rd_en,
    input  logic [AW-1:0]  rd_row,
    input  logic [AW-1:0]  rd_col,
    output logic [W_W-1:0] weight_ele
);

    localparam int KW    = 2 * AW;
    localparam int DEPTH = N * N;
    localparam logic [KW-1:0]  K_LAST  = {KW{1'b1}};
    localparam logic [7:0]     MAX_CNT = 8'(MAX_PATT);
    localparam logic [W_W-1:0] W_MAX   = {1'b0, {(W_W-1){1'b1}}};
    localparam logic [W_W-1:0] W_MIN   = {1'b1, {(W_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      count_q, count_d;
    logic [N-1:0]    patt_q, patt_d;
    logic [W_W-1:0]  weight_q;

    logic [W_W-1:0]  mem [DEPTH];
    logic            mem_we;
    logic [W_W-1:0]  mem_wdata;

    logic [AW-1:0]   row_k, col_k;
    logic [W_W-1:0]  w_cur;
    logic            bits_equal;
    logic [W_W:0]    sum_ext;
    logic [W_W-1:0]  acc_val;

    assign busy       = (state_q != ST_IDLE);
    assign patt_ready = (state_q == ST_IDLE) && (count_q < MAX_CNT);
    assign patt_count = count_q;
    assign weight_ele = weight_q;

    // Hebbian update for the entry under the sweep index: +1 on agreeing bits, -1 otherwise,
    // added one bit wider and clamped so the weight pins at the rail instead of wrapping.
    assign row_k      = k_q[KW-1:AW];
    assign col_k      = k_q[AW-1:0];
    assign w_cur      = mem[k_q];
    assign bits_equal = (patt_q[row_k] == patt_q[col_k]);

    always_comb begin
        sum_ext = {w_cur[W_W-1], w_cur} + (bits_equal ? (W_W+1)'(1) : {(W_W+1){1'b1}});
        acc_val = sum_ext[W_W-1:0];
        if (sum_ext[W_W] != sum_ext[W_W-1]) begin
            acc_val = sum_ext[W_W] ? W_MIN : W_MAX;
        end
        if (row_k == col_k) begin
            acc_val = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        count_d   = count_q;
        patt_d    = patt_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    k_d     = '0;
                    count_d = '0;
                end else if (patt_valid && patt_ready) begin
                    state_d = ST_ACCUM;
                    k_d     = '0;
                    patt_d  = patt_in;
                    count_d = count_q + 8'd1;
                end
            end
            ST_ACCUM: begin
                mem_we    = 1'b1;
                mem_wdata = acc_val;
                k_d       = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_CLEAR;
            k_q      <= '0;
            count_q  <= '0;
            patt_q   <= '0;
            weight_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            count_q  <= count_d;
            patt_q   <= patt_d;
            weight_q <= (rd_en && !busy) ? mem[{rd_row, rd_col}] : '0;
        end
    end

    // Array is deliberately unreset; the CLEAR sweep after every reset zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[k_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_hopfield_weight_trainer.sv
// Self-checking bench: two trainer instances (MAX_PATT=4 and MAX_PATT=200) against a
// plain-integer Hebbian reference matrix.
module tb_hopfield_weight_trainer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        a_valid = 0, a_ready, a_clear = 0, a_busy, a_rd_en = 0;
    logic [15:0] a_patt = '0;
    logic [7:0]  a_count, a_w;
    logic [3:0]  a_row = '0, a_col = '0;

    logic        b_valid = 0, b_ready, b_clear = 0, b_busy, b_rd_en = 0;
    logic [15:0] b_patt = '0;
    logic [7:0]  b_count, b_w;
    logic [3:0]  b_row = '0, b_col = '0;

    hopfield_weight_trainer #(.N(16), .W_W(8), .MAX_PATT(4)) dut_a (
        .clk(clk), .rst(rst), .patt_valid(a_valid), .patt_ready(a_ready), .patt_in(a_patt),
        .clear(a_clear), .busy(a_busy), .patt_count(a_count), .rd_en(a_rd_en),
        .rd_row(a_row), .rd_col(a_col), .weight_ele(a_w));

    hopfield_weight_trainer #(.N(16), .W_W(8), .MAX_PATT(200)) dut_b (
        .clk(clk), .rst(rst), .patt_valid(b_valid), .patt_ready(b_ready), .patt_in(b_patt),
        .clear(b_clear), .busy(b_busy), .patt_count(b_count), .rd_en(b_rd_en),
        .rd_row(b_row), .rd_col(b_col), .weight_ele(b_w));

    int checks = 0;
    int errors = 0;
    int m [16][16];
    logic [7:0] cap [256];

    function automatic void model_clear();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                m[i][j] = 0;
    endfunction

    function automatic void model_train(input logic [15:0] p);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                if (i != j) begin
                    int v;
                    v = m[i][j] + ((p[i] == p[j]) ? 1 : -1);
                    if (v > 127) v = 127;
                    if (v < -128) v = -128;
                    m[i][j] = v;
                end
    endfunction

    function automatic int model_diff();
        int nbad = 0;
        for (int a = 0; a < 256; a++)
            if (cap[a] !== 8'(m[a / 16][a % 16])) nbad++;
        return nbad;
    endfunction

    // Drives one request cycle on dut_a, then counts edges until busy falls (bounded).
    task automatic pulse_a(input logic do_clear, input logic do_valid, input logic [15:0] p,
                           input int clear_at, output int edges);
        a_patt = p; a_valid = do_valid; a_clear = do_clear;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0; a_clear = 0;
        edges = 0;
        do begin
            a_clear = (clear_at != 0 && edges == clear_at);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (a_busy && edges < 400);
        a_clear = 0;
    endtask

    task automatic train_b(input logic [15:0] p, output int edges);
        b_patt = p; b_valid = 1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 0;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (b_busy && edges < 400);
    endtask

    task automatic sweep_a();
        a_rd_en = 1; a_row = 0; a_col = 0;
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            cap[a] = a_w;
            if (a < 255) begin
                a_row = 4'((a + 1) / 16);
                a_col = 4'((a + 1) % 16);
            end
        end
        a_rd_en = 0;
    endtask

    task automatic test_reset();
        int edges, nbad;
        #2 rst = 0;
        #1;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", a_busy); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        checks++; if (a_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
        checks++; if (a_w !== 8'h00) begin errors++; $display("FAIL reset_weight: got %h want 00", a_w); end
        repeat (3) @(negedge clk);
        rst = 1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (a_busy && edges < 400);
        checks++; if (edges !== 256) begin errors++; $display("FAIL reset_clear_len: got %0d want 256", edges); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", a_ready); end
        model_clear();
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL reset_sweep: %0d nonzero entries, want 0", nbad); end
    endtask

    task automatic test_single_pattern();
        int edges, nbad;
        logic [7:0] got;
        pulse_a(0, 1, 16'h8EE8, 0, edges);
        model_train(16'h8EE8);
        checks++; if (edges !== 256) begin errors++; $display("FAIL single_busy_len: got %0d want 256", edges); end
        checks++; if (a_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d want 1", a_count); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", a_ready); end
        a_rd_en = 1; a_row = 0; a_col = 1;
        @(negedge clk); got = a_w; a_row = 0; a_col = 3;
        checks++; if (got !== 8'h01) begin errors++; $display("FAIL single_rd_0_1: got %h want 01", got); end
        @(negedge clk); got = a_w; a_row = 3; a_col = 0;
        checks++; if (got !== 8'hFF) begin errors++; $display("FAIL single_rd_0_3: got %h want ff", got); end
        @(negedge clk); got = a_w; a_row = 5; a_col = 5;
        checks++; if (got !== 8'hFF) begin errors++; $display("FAIL single_rd_3_0: got %h want ff", got); end
        @(negedge clk); got = a_w; a_rd_en = 0; a_row = 0; a_col = 1;
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL single_rd_5_5: got %h want 00", got); end
        @(negedge clk); got = a_w;
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL single_rd_disabled: got %h want 00", got); end
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL single_sweep: %0d entries differ, want 0", nbad); end
    endtask

    task automatic test_back_to_back();
        int edges, nbad, badlen;
        logic [15:0] pats [4];
        logic [7:0] got;
        pats[0] = 16'h8EE8; pats[1] = 16'h8ABB; pats[2] = 16'h1DDD; pats[3] = 16'h0666;
        pulse_a(1, 0, 16'h0, 0, edges);
        model_clear();
        checks++; if (edges !== 256 || a_count !== 8'd0) begin
            errors++; $display("FAIL b2b_clear: len %0d count %0d want 256/0", edges, a_count);
        end
        badlen = 0;
        for (int p = 0; p < 4; p++) begin
            pulse_a(0, 1, pats[p], 0, edges);
            model_train(pats[p]);
            if (edges != 256) badlen++;
        end
        checks++; if (badlen !== 0) begin errors++; $display("FAIL b2b_busy_len: %0d bad sweeps want 0", badlen); end
        checks++; if (a_count !== 8'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", a_count); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b want 0", a_ready); end
        a_rd_en = 1; a_row = 0; a_col = 3;
        @(negedge clk); got = a_w; a_row = 0; a_col = 1;
        checks++; if (got !== 8'h02) begin errors++; $display("FAIL b2b_rd_0_3: got %h want 02", got); end
        @(negedge clk); got = a_w; a_rd_en = 0;
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL b2b_rd_0_1: got %h want 00", got); end
        a_valid = 1; a_patt = 16'hFFFF;
        repeat (5) @(negedge clk);
        a_valid = 0;
        checks++; if (a_count !== 8'd4 || a_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_fifth_dropped: count %0d busy %b want 4/0", a_count, a_busy);
        end
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL b2b_sweep: %0d entries differ, want 0", nbad); end
    endtask

    task automatic test_random_patterns();
        int edges, nbad;
        logic [15:0] p;
        logic [3:0] r, c;
        logic en;
        logic [7:0] exp_w, got;
        pulse_a(1, 0, 16'h0, 0, edges);
        model_clear();
        for (int n = 0; n < 4; n++) begin
            p = 16'($urandom);
            pulse_a(0, 1, p, 0, edges);
            model_train(p);
        end
        checks++; if (a_count !== 8'd4) begin errors++; $display("FAIL rand_count: got %0d want 4", a_count); end
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL rand_sweep: %0d entries differ, want 0", nbad); end
        r = 4'($urandom); c = 4'($urandom); en = 1'($urandom);
        a_row = r; a_col = c; a_rd_en = en;
        for (int n = 0; n < 64; n++) begin
            exp_w = en ? 8'(m[r][c]) : 8'h00;
            @(negedge clk);
            got = a_w;
            checks++; if (got !== exp_w) begin
                errors++; $display("FAIL rand_read (%0d,%0d,en=%b): got %h want %h", r, c, en, got, exp_w);
            end
            r = 4'($urandom); c = 4'($urandom); en = 1'($urandom);
            a_row = r; a_col = c; a_rd_en = en;
        end
        a_rd_en = 0;
        @(negedge clk);
    endtask

    task automatic test_clear_rules();
        int edges, nbad;
        logic [7:0] got;
        pulse_a(1, 0, 16'h0, 0, edges);
        model_clear();
        pulse_a(0, 1, 16'h8EE8, 50, edges);
        model_train(16'h8EE8);
        checks++; if (edges !== 256) begin errors++; $display("FAIL clr_accum_len: got %0d want 256", edges); end
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_count !== 8'd1) begin
            errors++; $display("FAIL clr_not_queued: busy %b count %0d want 0/1", a_busy, a_count);
        end
        a_rd_en = 1; a_row = 0; a_col = 3;
        @(negedge clk); got = a_w; a_rd_en = 0;
        checks++; if (got !== 8'hFF) begin errors++; $display("FAIL clr_rd_0_3: got %h want ff", got); end
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL clr_accum_sweep: %0d entries differ, want 0", nbad); end
        pulse_a(1, 1, 16'($urandom), 0, edges);
        model_clear();
        checks++; if (edges !== 256) begin errors++; $display("FAIL clr_wins_len: got %0d want 256", edges); end
        checks++; if (a_count !== 8'd0) begin errors++; $display("FAIL clr_wins_count: got %0d want 0", a_count); end
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL clr_wins_sweep: %0d nonzero entries, want 0", nbad); end
    endtask

    task automatic test_reset_mid_sweep();
        int edges, nbad;
        pulse_a(0, 1, 16'h5A3C, 0, edges);
        a_patt = 16'hC3A5; a_valid = 1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (a_busy !== 1'b1 || a_count !== 8'd0 || a_w !== 8'h00 || a_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_async: busy %b count %0d w %h ready %b want 1/0/00/0",
                               a_busy, a_count, a_w, a_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (a_busy && edges < 400);
        checks++; if (edges !== 256) begin errors++; $display("FAIL midrst_clear_len: got %0d want 256", edges); end
        model_clear();
        sweep_a();
        nbad = model_diff();
        checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_sweep: %0d nonzero entries, want 0", nbad); end
    endtask

    task automatic test_saturation();
        int edges, badlen, v01, v08;
        logic [7:0] got;
        v01 = 0; v08 = 0; badlen = 0;
        for (int n = 0; n < 130; n++) begin
            train_b(16'hFFFF, edges);
            if (edges != 256) badlen++;
            v01 = (v01 + 1 > 127) ? 127 : v01 + 1;
            v08 = (v08 + 1 > 127) ? 127 : v08 + 1;
        end
        checks++; if (badlen !== 0 || b_count !== 8'd130) begin
            errors++; $display("FAIL sat_train: bad sweeps %0d count %0d want 0/130", badlen, b_count);
        end
        b_rd_en = 1; b_row = 0; b_col = 1;
        @(negedge clk); got = b_w; b_rd_en = 0;
        checks++; if (got !== 8'(v01)) begin errors++; $display("FAIL sat_rd_0_1: got %h want %h", got, 8'(v01)); end
        train_b(16'h00FF, edges);
        v01 = (v01 + 1 > 127) ? 127 : v01 + 1;
        v08 = v08 - 1;
        b_rd_en = 1; b_row = 0; b_col = 8;
        @(negedge clk); got = b_w; b_row = 0; b_col = 1;
        checks++; if (got !== 8'(v08) || got !== 8'h7E) begin
            errors++; $display("FAIL sat_rd_0_8: got %h want %h", got, 8'(v08));
        end
        @(negedge clk); got = b_w; b_rd_en = 0;
        checks++; if (got !== 8'(v01) || got !== 8'h7F) begin
            errors++; $display("FAIL sat_hold_0_1: got %h want %h", got, 8'(v01));
        end
    endtask

    initial begin
        test_reset();
        test_single_pattern();
        test_back_to_back();
        test_random_patterns();
        test_clear_rules();
        test_reset_mid_sweep();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
